// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC sequencer: operand/product widths and
// the controller state encoding.
package mac_seq_ctrl_pkg;

  localparam int MAC_OP_W   = 8;
  localparam int MAC_PROD_W = 16;

  // 2-bit controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mac_state_e;

endpackage

// File: rtl/mac_seq_ctrl_mul8.sv
// Combinational unsigned 8x8 -> 16 multiplier used by the MAC sequencer.
module mul8
  import mac_seq_ctrl_pkg::*;
(
  input  logic [MAC_OP_W-1:0]   i_a,
  input  logic [MAC_OP_W-1:0]   i_b,
  output logic [MAC_PROD_W-1:0] o_p
);

  // Operands are zero-extended so the product is computed at full width
  assign o_p = {{(MAC_PROD_W-MAC_OP_W){1'b0}}, i_a} * {{(MAC_PROD_W-MAC_OP_W){1'b0}}, i_b};

endmodule

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: takes a job length, streams that many operand pairs
// through mul8 into an accumulator, and offers the sum on a result port.
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    len,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAC_OP_W-1:0] a,
  input  logic [MAC_OP_W-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_W-1:0]    acc_out,
  output logic                ovf
);

  mac_state_e              r_state;
  logic                    r_busy;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic [CNT_W-1:0]        r_rem;

  logic [MAC_PROD_W-1:0]   r_prod_p1;
  logic                    r_vld_p1;
  logic [ACC_W-1:0]        r_acc_p2;
  logic                    r_ovf_p2;

  logic                    w_accept;
  logic                    w_job_start;
  logic [MAC_PROD_W-1:0]   w_prod;
  logic [ACC_W:0]          w_sum;

  // Unsigned add one bit wider than the accumulator; the MSB is the carry out
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0]      acc,
                                             input logic [MAC_PROD_W-1:0] prod);
    return {1'b0, acc} + {{(ACC_W+1-MAC_PROD_W){1'b0}}, prod};
  endfunction

  mul8 u_mul (
    .i_a (a),
    .i_b (b),
    .o_p (w_prod)
  );

  // in_ready is high exactly in LOAD, so this is the pair-accept strobe
  assign w_accept    = in_valid & r_in_ready;
  assign w_job_start = (r_state == ST_IDLE) & start;
  assign w_sum       = acc_add(r_acc_p2, r_prod_p1);

  // Controller: state, remaining-pair counter and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_rem       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (len != '0) begin
              r_state    <= ST_LOAD;
              r_rem      <= len;
              r_in_ready <= 1'b1;
            end else begin
              // Empty job: no pairs are taken, the cleared sum is the result
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_rem <= r_rem - CNT_W'(1);
            if (r_rem == CNT_W'(1)) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // Last product is folded during this cycle
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          // start is deliberately not looked at here, even on the handshake cycle
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stage p1: capture the product of each accepted pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod_p1 <= '0;
      r_vld_p1  <= 1'b0;
    end else if (w_job_start) begin
      r_vld_p1 <= 1'b0;
    end else begin
      // The flag only lives one cycle so a bubble never folds a product twice
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_prod_p1 <= w_prod;
      end
    end
  end

  // Stage p2: fold the captured product into the accumulator, track carry out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_p2 <= '0;
      r_ovf_p2 <= 1'b0;
    end else if (w_job_start) begin
      r_acc_p2 <= '0;
      r_ovf_p2 <= 1'b0;
    end else if (r_vld_p1) begin
      r_acc_p2 <= w_sum[ACC_W-1:0];
      r_ovf_p2 <= r_ovf_p2 | w_sum[ACC_W];
    end
  end

  assign busy      = r_busy;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign acc_out   = r_acc_p2;
  assign ovf       = r_ovf_p2;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: two instances (24-bit and 16-bit accumulators)
// share one directed stimulus stream and are checked against a job-level model.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = 8'd0;
  logic [7:0]  b = 8'd0;
  logic        out_ready = 1'b0;

  logic        busy, in_ready, out_valid, ovf;
  logic [23:0] acc_out;
  logic        busy16, in_ready16, out_valid16, ovf16;
  logic [15:0] acc16;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mac_seq_ctrl #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  mac_seq_ctrl #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .a(a), .b(b),
    .out_valid(out_valid16), .out_ready(out_ready), .acc_out(acc16), .ovf(ovf16)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Job-level model: 0 = idle, 1 = taking pairs, 2 = finishing last pair, 3 = result offered
  int     m_phase = 0;
  int     m_left  = 0;
  longint m_sum   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      m_sum   = 0;
    end else begin
      case (m_phase)
        0: if (start) begin
             m_sum = 0;
             if (len == 8'd0) m_phase = 3;
             else begin
               m_left  = int'(len);
               m_phase = 1;
             end
           end
        1: if (in_valid) begin
             m_sum  = m_sum + longint'(a) * longint'(b);
             m_left = m_left - 1;
             if (m_left == 0) m_phase = 2;
           end
        2: m_phase = 3;
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy",        32'(busy),        32'(m_phase != 0));
      chk("in_ready",    32'(in_ready),    32'(m_phase == 1));
      chk("out_valid",   32'(out_valid),   32'(m_phase == 3));
      chk("busy16",      32'(busy16),      32'(m_phase != 0));
      chk("in_ready16",  32'(in_ready16),  32'(m_phase == 1));
      chk("out_valid16", 32'(out_valid16), 32'(m_phase == 3));
      if (m_phase == 3) begin
        chk("acc24", 32'(acc_out), 32'(m_sum % 64'd16777216));
        chk("ovf24", 32'(ovf),     32'(m_sum >= 64'd16777216));
        chk("acc16", 32'(acc16),   32'(m_sum % 64'd65536));
        chk("ovf16", 32'(ovf16),   32'(m_sum >= 64'd65536));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [7:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Present one pair after 'gap' bubble cycles (junk on a/b) and hold it until accepted
  task automatic send(input logic [7:0] pa, input logic [7:0] pb, input int gap);
    in_valid = 1'b0;
    a = 8'd99;
    b = 8'd77;
    repeat (gap) tick();
    in_valid = 1'b1;
    a = pa;
    b = pb;
    for (int n = 0; n < 20 && !in_ready; n++) tick();
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   32'(busy),      32'd0);
    chk({tag, "_inrdy"},  32'(in_ready),  32'd0);
    chk({tag, "_ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, "_acc"},    32'(acc_out),   32'd0);
    chk({tag, "_ovf"},    32'(ovf),       32'd0);
    chk({tag, "_busy16"}, 32'(busy16),    32'd0);
    chk({tag, "_ovld16"}, 32'(out_valid16), 32'd0);
    chk({tag, "_acc16"},  32'(acc16),     32'd0);
    chk({tag, "_ovf16"},  32'(ovf16),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3;
    chk_all_zero("rst");
    #9;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    tick();

    // 1: back-to-back pairs, latency of the result
    start_job(8'd3);
    send(8'd2, 8'd3, 0);
    send(8'd4, 8'd5, 0);
    send(8'd255, 8'd255, 0);
    chk("t1_drain_ovalid", 32'(out_valid), 32'd0);
    tick();
    chk("t1_ovalid", 32'(out_valid), 32'd1);
    chk("t1_acc",    32'(acc_out),   32'd65051);
    chk("t1_ovf",    32'(ovf),       32'd0);
    chk("t1_acc16",  32'(acc16),     32'd65051);
    take();
    chk("t1_idle", 32'(busy), 32'd0);

    // 2: gaps of 0..3 bubble cycles
    start_job(8'd4);
    send(8'd1, 8'd1, 0);
    send(8'd10, 8'd10, 1);
    send(8'd0, 8'd200, 2);
    send(8'd16, 8'd16, 3);
    wait_done();
    chk("t2_acc", 32'(acc_out), 32'd357);
    take();

    // 3: empty job goes straight to the result
    start_job(8'd0);
    chk("t3_ovalid", 32'(out_valid), 32'd1);
    chk("t3_acc",    32'(acc_out),   32'd0);
    chk("t3_inrdy",  32'(in_ready),  32'd0);
    take();

    // 4: stalled consumer, start pulses during DONE are ignored
    start_job(8'd1);
    send(8'd7, 8'd9, 0);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1;
        len   = 8'd3;
      end
      tick();
      start = 1'b0;
      chk("t4_acc_hold", 32'(acc_out),   32'd63);
      chk("t4_ov_hold",  32'(out_valid), 32'd1);
    end
    start = 1'b1;
    len   = 8'd2;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    chk("t4_idle_busy",   32'(busy),      32'd0);
    chk("t4_idle_ovalid", 32'(out_valid), 32'd0);
    tick();
    chk("t4_start_dropped", 32'(busy), 32'd0);

    // 5: carry out of a 16-bit accumulator, then a clean job
    start_job(8'd2);
    send(8'd255, 8'd255, 0);
    send(8'd255, 8'd255, 0);
    wait_done();
    chk("t5_acc16", 32'(acc16),   32'd64514);
    chk("t5_ovf16", 32'(ovf16),   32'd1);
    chk("t5_acc24", 32'(acc_out), 32'd130050);
    chk("t5_ovf24", 32'(ovf),     32'd0);
    take();
    start_job(8'd1);
    send(8'd1, 8'd1, 0);
    wait_done();
    chk("t5b_acc16", 32'(acc16), 32'd1);
    chk("t5b_ovf16", 32'(ovf16), 32'd0);
    take();

    // 6: asynchronous reset in the middle of a job
    start_job(8'd5);
    send(8'd1, 8'd2, 0);
    send(8'd3, 8'd4, 0);
    chk("t6_busy_before", 32'(busy), 32'd1);
    in_valid = 1'b1;
    a = 8'd5;
    b = 8'd6;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6");
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_job(8'd1);
    send(8'd3, 8'd3, 0);
    wait_done();
    chk("t6_acc", 32'(acc_out), 32'd9);
    take();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
